// File: rtl/sram_port_arbiter_if.sv
// sram-like request/response bundle shared by the fetch, data and memory sides.
// The arbiter is the slave of both masters and the master of the memory port.
interface sram_port_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-master arbiter onto one sram-like port; an owner FIFO routes each
// in-order response back to the master whose request was accepted.
//
// state      | meaning
// S_IDLE     | no request waiting on mem_addr_ok; grant chosen freshly each cycle
// S_LOCK_INS | fetch request presented but not yet accepted; fetch keeps the grant
// S_LOCK_DAT | data request presented but not yet accepted; data keeps the grant
module sram_port_arbiter #(
    parameter int MAX_OUTST  = 4,
    parameter int STARVE_LIM = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    sram_port_arbiter_if.slave           inst_if,
    sram_port_arbiter_if.slave           data_if,
    sram_port_arbiter_if.master          mem_if,
    output logic [$clog2(MAX_OUTST):0]   outst_cnt,
    output logic                         proto_err
);
    localparam int PW = $clog2(MAX_OUTST);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOCK_INS = 2'd1,
        S_LOCK_DAT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [MAX_OUTST-1:0]   owner_q, owner_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SW-1:0]          starve_q, starve_d;
    logic                   proto_err_q, proto_err_d;

    logic full, gnt_data, sel_inst, req_g, mem_req, accept, pop, head;

    always_comb begin
        full     = (cnt_q == CW'(MAX_OUTST));
        sel_inst = inst_if.req & (~data_if.req | (starve_q >= SW'(STARVE_LIM)));
        gnt_data = 1'b0;
        case (state_q)
            S_LOCK_INS: gnt_data = 1'b0;
            S_LOCK_DAT: gnt_data = 1'b1;
            default:    gnt_data = data_if.req & ~sel_inst;
        endcase
        req_g   = gnt_data ? data_if.req : inst_if.req;
        mem_req = req_g & ~full;
        accept  = mem_req & mem_if.addr_ok;
        pop     = mem_if.data_ok & (cnt_q != '0);
        head    = owner_q[rd_ptr_q];

        state_d     = S_IDLE;
        owner_d     = owner_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        proto_err_d = proto_err_q | (mem_if.data_ok & (cnt_q == '0));

        // Hold the grant until the presented request is accepted or withdrawn.
        if (mem_req && !mem_if.addr_ok) begin
            state_d = gnt_data ? S_LOCK_DAT : S_LOCK_INS;
        end

        if (accept) begin
            owner_d[wr_ptr_q] = gnt_data;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(accept) - CW'(pop);

        if (!inst_if.req || (accept && !gnt_data)) begin
            starve_d = '0;
        end else if (accept && gnt_data && (starve_q < SW'(STARVE_LIM))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            starve_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign mem_if.req   = mem_req;
    assign mem_if.wr    = gnt_data ? data_if.wr    : inst_if.wr;
    assign mem_if.size  = gnt_data ? data_if.size  : inst_if.size;
    assign mem_if.wstrb = gnt_data ? data_if.wstrb : inst_if.wstrb;
    assign mem_if.addr  = gnt_data ? data_if.addr  : inst_if.addr;
    assign mem_if.wdata = gnt_data ? data_if.wdata : inst_if.wdata;

    assign inst_if.addr_ok = accept & ~gnt_data;
    assign data_if.addr_ok = accept & gnt_data;
    assign inst_if.data_ok = pop & ~head;
    assign data_if.data_ok = pop & head;
    assign inst_if.rdata   = mem_if.rdata;
    assign data_if.rdata   = mem_if.rdata;

    assign outst_cnt = cnt_q;
    assign proto_err = proto_err_q;
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Shares one sram-like memory port between the instruction-fetch master (inst_sram_*) and the data-access master (data_sram_*). It tracks outstanding accepted requests in order, so each mem_data_ok and its read data return to the master that issued the request. It sits between the pipeline and the downstream sram-like-to-AXI bridge or cache.

Parameters:
MAX_OUTST, 4, maximum accepted-but-not-returned requests (power of 2, ≥2)
STARVE_LIM, 4, consecutive data grants while inst is pending before inst is forced to win

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
inst_req  in  1  fetch request
inst_wr  in  1  fetch write flag (always 0 in practice; forwarded unchanged)
inst_size  in  2  fetch access size
inst_wstrb  in  4  fetch byte strobes
inst_addr  in  32  fetch address
inst_wdata  in  32  fetch write data
inst_addr_ok  out  1  fetch request accepted
inst_data_ok  out  1  fetch response valid
inst_rdata  out  32  fetch read data
data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data master request, same meanings as inst_*
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  data response valid
data_rdata  out  32  data read data
mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/1/2/4/32/32  shared port request
mem_addr_ok  in  1  shared port accepted the request
mem_data_ok  in  1  shared port response valid
mem_rdata  in  32  shared port read data
outst_cnt  out  $clog2(MAX_OUTST)+1  number of outstanding requests
proto_err  out  1  sticky: mem_data_ok was seen with nothing outstanding

Behaviour:
- Reset (rstn=0 at a clk edge): owner FIFO empty, outst_cnt=0, lock=0, starve_cnt=0, proto_err=0. All *_addr_ok, *_data_ok and mem_req are 0 during and after reset until new requests arrive.
- full = (outst_cnt == MAX_OUTST).

Grant selection (combinational, used only when lock=0):
- Pick inst if inst_req & (!data_req | starve_cnt ≥ STARVE_LIM).
- Otherwise pick data if data_req.
- Otherwise no grant.

Lock register:
- If mem_req=1 and mem_addr_ok=0, set lock=1 and store the granted owner.
- While lock=1, the stored owner stays granted, whatever the other master does, until mem_addr_ok. This holds request fields stable as the sram-like protocol requires.
- lock clears on the cycle mem_addr_ok=1.
- If the locked master drops its req, mem_req drops and lock clears. This is a protocol violation by that master; no recovery beyond that is done.

mem port:
- mem_req = granted master's req & !full.
- mem_* request fields are muxed from the granted master. With no grant, the fields come from the inst master.

Accept handshake:
- granted *_addr_ok = mem_addr_ok & mem_req. The non-granted master's addr_ok = 0.
- On accept, push the owner bit (0=inst, 1=data) into the FIFO. The FIFO is a circular buffer; wr_ptr/rd_ptr wrap modulo MAX_OUTST.

Response routing:
- On mem_data_ok with the FIFO non-empty, route to the head owner and pop: head_owner ? data_data_ok : inst_data_ok = 1.
- Both inst_rdata and data_rdata = mem_rdata, combinational, zero latency.
- A simultaneous push and pop in the same cycle leaves outst_cnt unchanged. Full-then-pop does not allow a push in the same cycle, because full gates mem_req combinationally.

Spurious response:
- mem_data_ok with the FIFO empty: no *_data_ok is raised, proto_err sets and stays 1 until reset.

starve_cnt:
- Increments (saturating at STARVE_LIM) on each data accept while inst_req=1.
- Clears on an inst accept, or whenever inst_req=0.

Reset mid-operation:
- All outstanding state is discarded.
- Late mem_data_ok after reset is flagged via proto_err.

Test Plan:
- Idle to inst only: inst_req=1, addr=0x1C000000, mem_addr_ok=1 -> mem_addr=0x1C000000, inst_addr_ok=1, outst_cnt 0→1. Then mem_data_ok=1, mem_rdata=0x02800000 -> inst_data_ok=1, inst_rdata=0x02800000, data_data_ok=0, outst_cnt=0.
- Contention with in-order return: both req in the same cycle -> data accepted first, then inst. Two mem_data_ok pulses -> data_data_ok on the first, inst_data_ok on the second.
- Lock hold: data_req with mem_addr_ok=0 for 3 cycles while inst_req rises in cycle 2 -> mem_addr stays at data_addr for all 3 cycles, inst_addr_ok=0. Accept occurs in cycle 4.
- Full: MAX_OUTST=4 accepts with no responses -> outst_cnt=4, mem_req=0 despite pending reqs. One mem_data_ok -> next cycle mem_req=1 again.
- Starvation: data_req and inst_req held at 1, mem_addr_ok=1 -> 4 data accepts, then one inst accept, then starve_cnt=0 and data wins again.
- Spurious response and reset: mem_data_ok with outst_cnt=0 -> no data_ok, proto_err=1 sticky. Pulse rstn=0 with 2 outstanding -> outst_cnt=0, proto_err=0.
